// File: rtl/cap17_sel_pkg.sv
// Shared constants for the CAP17 one-hot select unit: mode codes,
// FSM state encodings and the internal counter width.
package cap17_sel_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;
    localparam logic [1:0] ST_PULSE  = 2'd3;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/sel_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder; all-zero when disabled.
module sel_onehot_dec #(
    parameter  int unsigned SEL_W = 3,
    localparam int unsigned OUT_W = 2 ** SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dec
);

    // Set exactly the selected line when enabled.
    always_comb begin
        dec = '0;
        if (en) begin
            dec[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/onehot_select_unit.sv
// Registered one-hot select generator with DIRECT, SCAN and timed PULSE
// modes. The single decoder is driven by the next-cycle line index and
// enable, so dec_out and idx_out are always updated together.
module onehot_select_unit
    import cap17_sel_pkg::*;
#(
    parameter  int unsigned SEL_W     = 3,
    parameter  int unsigned PULSE_LEN = 4,
    parameter  int unsigned SCAN_DIV  = 1,
    localparam int unsigned OUT_W     = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             start,
    output logic [OUT_W-1:0] dec_out,
    output logic [SEL_W-1:0] idx_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] dec_q, dec_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

    logic             dec_on;
    logic [SEL_W-1:0] dec_idx;

    // Next-state, next-line and counter logic; counters and strobes clear by default.
    always_comb begin
        state_d     = state_q;
        dec_on      = 1'b0;
        dec_idx     = idx_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        scan_cnt_d  = '0;
        pulse_cnt_d = '0;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    case (mode)
                        MODE_DIRECT: begin
                            state_d = ST_DIRECT;
                            dec_on  = 1'b1;
                            dec_idx = sel_in;
                        end
                        MODE_SCAN: begin
                            state_d = ST_SCAN;
                            dec_on  = 1'b1;
                            dec_idx = '0;
                        end
                        MODE_PULSE: begin
                            if (start) begin
                                state_d     = ST_PULSE;
                                dec_on      = 1'b1;
                                dec_idx     = sel_in;
                                busy_d      = 1'b1;
                                pulse_cnt_d = PULSE_LOAD;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                ST_DIRECT: begin
                    if (mode == MODE_DIRECT) begin
                        dec_on  = 1'b1;
                        dec_idx = sel_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (mode == MODE_SCAN) begin
                        dec_on = 1'b1;
                        if (scan_cnt_q == SCAN_LAST) begin
                            dec_idx = idx_q + SEL_W'(1);
                            done_d  = (idx_q == '1);
                        end else begin
                            scan_cnt_d = scan_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        dec_on      = 1'b1;
                        busy_d      = 1'b1;
                        pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    sel_onehot_dec #(
        .SEL_W(SEL_W)
    ) u_dec (
        .en (dec_on),
        .sel(dec_idx),
        .dec(dec_d)
    );

    // idx_out tracks the decoder index, which holds its last value when no line is on.
    assign idx_d = dec_idx;

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dec_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            scan_cnt_q  <= '0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            scan_cnt_q  <= scan_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign dec_out = dec_q;
    assign idx_out = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_onehot_select_unit.sv
// Self-checking bench for onehot_select_unit: randomized stimulus against a
// behavioural model that tracks elapsed scan time and remaining pulse length.
module tb_onehot_select_unit;

    localparam int PULSE_LEN = 4;
    localparam int SCAN_DIV  = 2;
    localparam int OUT_W     = 8;

    localparam int M_IDLE   = 0;
    localparam int M_DIRECT = 1;
    localparam int M_SCAN   = 2;
    localparam int M_PULSE  = 3;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [2:0]  sel_in;
    logic        start;
    logic [7:0]  dec_out;
    logic [2:0]  idx_out;
    logic        busy;
    logic        done;

    logic        w_en;
    logic [1:0]  w_mode;
    logic [3:0]  w_sel;
    logic        w_start;
    logic [15:0] w_dec;
    logic [3:0]  w_idx;
    logic        w_busy;
    logic        w_done;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_st;
    int         m_t;
    int         m_left;
    logic [7:0] m_dec;
    logic [2:0] m_idx;
    logic       m_busy;
    logic       m_done;

    onehot_select_unit #(
        .SEL_W(3),
        .PULSE_LEN(PULSE_LEN),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
        .start(start), .dec_out(dec_out), .idx_out(idx_out), .busy(busy), .done(done)
    );

    onehot_select_unit #(
        .SEL_W(4)
    ) u_wide (
        .clk(clk), .rst_n(rst_n), .en(w_en), .mode(w_mode), .sel_in(w_sel),
        .start(w_start), .dec_out(w_dec), .idx_out(w_idx), .busy(w_busy), .done(w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = M_IDLE; m_t = 0; m_left = 0;
        m_dec = '0; m_idx = '0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    // One clock of the reference behaviour, from the inputs seen at that edge.
    task automatic model_step(input logic e, input logic [1:0] md, input logic [2:0] s, input logic st);
        m_done = 1'b0;
        if (!e) begin
            m_st = M_IDLE; m_dec = '0; m_busy = 1'b0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (md == 2'b00) begin
                        m_st = M_DIRECT; m_idx = s; m_dec = '0; m_dec[s] = 1'b1;
                    end else if (md == 2'b01) begin
                        m_st = M_SCAN; m_t = 0; m_idx = '0; m_dec = 8'h01;
                    end else if (md == 2'b10 && st) begin
                        m_st = M_PULSE; m_left = PULSE_LEN; m_idx = s; m_busy = 1'b1;
                        m_dec = '0; m_dec[s] = 1'b1;
                    end else begin
                        m_dec = '0;
                    end
                end
                M_DIRECT: begin
                    if (md == 2'b00) begin
                        m_idx = s; m_dec = '0; m_dec[s] = 1'b1;
                    end else begin
                        m_st = M_IDLE; m_dec = '0;
                    end
                end
                M_SCAN: begin
                    if (md == 2'b01) begin
                        m_t++;
                        m_idx  = 3'((m_t / SCAN_DIV) % OUT_W);
                        m_dec  = '0; m_dec[m_idx] = 1'b1;
                        m_done = ((m_t % (OUT_W * SCAN_DIV)) == 0);
                    end else begin
                        m_st = M_IDLE; m_dec = '0;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_st = M_IDLE; m_dec = '0; m_busy = 1'b0; m_done = 1'b1;
                    end
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle past it.
    task automatic tick(input logic e, input logic [1:0] md, input logic [2:0] s, input logic st);
        en = e; mode = md; sel_in = s; start = st;
        @(posedge clk);
        model_step(e, md, s, st);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0; mode = 2'b11; sel_in = '0; start = 1'b0;
        w_en = 1'b0; w_mode = 2'b11; w_sel = '0; w_start = 1'b0;
        #1;
        n_checks++;
        if ({dec_out, idx_out, busy, done} !== 13'd0)
            $display("FAIL reset_state: got dec=%h idx=%0d busy=%b done=%b, want all zero", dec_out, idx_out, busy, done);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick(1'b1, 2'b10, 3'd5, 1'b1);
        tick(1'b1, 2'b10, 3'd0, 1'b0);
        n_checks++;
        if ({dec_out, idx_out, busy, done} !== {m_dec, m_idx, m_busy, m_done})
            $display("FAIL reset_prepulse: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                     dec_out, idx_out, busy, done, m_dec, m_idx, m_busy, m_done);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dec_out, idx_out, busy, done} !== 13'd0)
            $display("FAIL reset_async: got dec=%h idx=%0d busy=%b done=%b, want all zero", dec_out, idx_out, busy, done);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick(1'b1, 2'b11, 3'd0, 1'b0);
        n_checks++;
        if ({dec_out, idx_out, busy, done} !== {m_dec, m_idx, m_busy, m_done})
            $display("FAIL reset_release: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                     dec_out, idx_out, busy, done, m_dec, m_idx, m_busy, m_done);
        else n_pass++;
    endtask

    task automatic test_direct();
        tick(1'b1, 2'b00, 3'd5, 1'b0);
        n_checks++;
        if (dec_out !== 8'h20 || idx_out !== 3'd5)
            $display("FAIL direct_sel5: got dec=%h idx=%0d want dec=20 idx=5", dec_out, idx_out);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 2'b00, 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
            n_checks++;
            if ({dec_out, idx_out, busy, done} !== {m_dec, m_idx, m_busy, m_done})
                $display("FAIL direct_rand: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         dec_out, idx_out, busy, done, m_dec, m_idx, m_busy, m_done);
            else n_pass++;
        end
        tick(1'b0, 2'b00, 3'd5, 1'b0);
        n_checks++;
        if (dec_out !== 8'h00 || {dec_out, idx_out, busy, done} !== {m_dec, m_idx, m_busy, m_done})
            $display("FAIL direct_en_drop: got dec=%h idx=%0d want dec=00 idx=%0d", dec_out, idx_out, m_idx);
        else n_pass++;
    endtask

    task automatic test_scan();
        int n_done = 0;
        tick(1'b1, 2'b11, 3'd0, 1'b0);
        for (int i = 0; i < 2 * OUT_W * SCAN_DIV + 2; i++) begin
            tick(1'b1, 2'b01, 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
            if (done) n_done++;
            n_checks++;
            if ({dec_out, idx_out, busy, done} !== {m_dec, m_idx, m_busy, m_done})
                $display("FAIL scan_step%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         i, dec_out, idx_out, busy, done, m_dec, m_idx, m_busy, m_done);
            else n_pass++;
        end
        n_checks++;
        if (n_done != 2)
            $display("FAIL scan_done_count: got %0d want 2", n_done);
        else n_pass++;
        tick(1'b1, 2'b00, 3'd2, 1'b0);
        n_checks++;
        if (dec_out !== 8'h00)
            $display("FAIL scan_leave: got dec=%h want 00", dec_out);
        else n_pass++;
    endtask

    task automatic test_pulse();
        int n_busy = 0;
        int n_line = 0;
        int n_done = 0;
        tick(1'b1, 2'b11, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      tick(1'b1, 2'b10, 3'd3, 1'b1);
            else if (i < 4)  tick(1'b1, 2'($urandom_range(3, 0)), 3'd6, 1'b1);
            else             tick(1'b1, 2'b11, 3'd6, 1'b0);
            if (busy) n_busy++;
            if (dec_out == 8'h08) n_line++;
            if (done) n_done++;
            n_checks++;
            if ({dec_out, idx_out, busy, done} !== {m_dec, m_idx, m_busy, m_done})
                $display("FAIL pulse_cycle%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         i, dec_out, idx_out, busy, done, m_dec, m_idx, m_busy, m_done);
            else n_pass++;
        end
        n_checks++;
        if (n_busy != PULSE_LEN || n_line != PULSE_LEN || n_done != 1)
            $display("FAIL pulse_counts: got busy=%0d line=%0d done=%0d want %0d/%0d/1",
                     n_busy, n_line, n_done, PULSE_LEN, PULSE_LEN);
        else n_pass++;
    endtask

    task automatic test_abort();
        int n_done = 0;
        tick(1'b1, 2'b10, 3'd2, 1'b1);
        tick(1'b1, 2'b10, 3'd2, 1'b0);
        tick(1'b0, 2'b10, 3'd2, 1'b0);
        n_checks++;
        if (dec_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_clear: got dec=%h busy=%b done=%b want 00/0/0", dec_out, busy, done);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 2'b11, 3'd2, 1'b0);
            if (done) n_done++;
        end
        n_checks++;
        if (n_done != 0)
            $display("FAIL abort_no_done: got %0d done strobes want 0", n_done);
        else n_pass++;
        tick(1'b0, 2'b10, 3'd1, 1'b1);
        tick(1'b1, 2'b11, 3'd1, 1'b0);
        n_checks++;
        if (busy !== 1'b0 || dec_out !== 8'h00 || {dec_out, idx_out, busy, done} !== {m_dec, m_idx, m_busy, m_done})
            $display("FAIL en_beats_start: got dec=%h busy=%b want 00/0", dec_out, busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_busy = 0;
        int n_done = 0;
        tick(1'b1, 2'b11, 3'd0, 1'b0);
        for (int i = 0; i < 2 * (PULSE_LEN + 1); i++) begin
            tick(1'b1, 2'b10, 3'd4, 1'b1);
            if (busy) n_busy++;
            if (done) n_done++;
            n_checks++;
            if ({dec_out, idx_out, busy, done} !== {m_dec, m_idx, m_busy, m_done})
                $display("FAIL b2b_cycle%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         i, dec_out, idx_out, busy, done, m_dec, m_idx, m_busy, m_done);
            else n_pass++;
        end
        n_checks++;
        if (n_busy != 2 * PULSE_LEN || n_done != 2)
            $display("FAIL b2b_counts: got busy=%0d done=%0d want %0d/2", n_busy, n_done, 2 * PULSE_LEN);
        else n_pass++;
        tick(1'b1, 2'b11, 3'd0, 1'b0);
        tick(1'b1, 2'b11, 3'd0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(9, 0) != 0), 2'($urandom_range(3, 0)),
                 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
            n_checks++;
            if ({dec_out, idx_out, busy, done} !== {m_dec, m_idx, m_busy, m_done} || !$onehot0(dec_out))
                $display("FAIL random%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         i, dec_out, idx_out, busy, done, m_dec, m_idx, m_busy, m_done);
            else n_pass++;
        end
    endtask

    task automatic test_wide();
        tick(1'b0, 2'b11, 3'd0, 1'b0);
        w_en = 1'b1; w_mode = 2'b00; w_sel = 4'd15; w_start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (w_dec !== 16'h8000 || w_idx !== 4'd15)
            $display("FAIL wide_sel15: got dec=%h idx=%0d want 8000/15", w_dec, w_idx);
        else n_pass++;
        for (int i = 0; i < 300; i++) begin
            w_en = 1'($urandom_range(9, 0) != 0);
            w_mode = 2'($urandom_range(3, 0));
            w_sel = 4'($urandom_range(15, 0));
            w_start = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            n_checks++;
            if (!$onehot0(w_dec) || (w_dec != 16'h0 && w_dec != (16'h1 << w_idx)))
                $display("FAIL wide_onehot%0d: got dec=%h idx=%0d", i, w_dec, w_idx);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_pulse();
        test_abort();
        test_back_to_back();
        test_random();
        test_wide();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/onehot_select_unit.md
# onehot_select_unit

Parametrised, registered one-hot select generator for the CAP17 datapath. It replaces the fixed 3-to-8 enable decoder with an N-to-2^N unit. It drives register-file write enables, peripheral chip selects and scan strobes. Besides plain registered decoding, it supports a rotating scan mode and a timed single-line pulse mode with busy/done handshake.

## Interface
- SEL_W, 3: select width; output width OUT_W = 2**SEL_W (derived localparam, not overridable).
- PULSE_LEN, 4: cycles a line stays asserted in PULSE mode; legal range 1..255.
- SCAN_DIV, 1: cycles per scan step in SCAN mode; legal range 1..255.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable; 0 forces outputs low on next edge.
- mode  in  2  00 DIRECT, 01 SCAN, 10 PULSE, 11 OFF.
- sel_in  in  SEL_W  line index for DIRECT/PULSE.
- start  in  1  PULSE-mode trigger, sampled in IDLE only.
- dec_out  out  OUT_W  registered one-hot (or all-zero) select.
- idx_out  out  SEL_W  index of currently asserted line (last value when dec_out=0).
- busy  out  1  high while a PULSE is in progress.
- done  out  1  one-cycle strobe: PULSE finished, or SCAN wrapped.

## Operation
- Reset (async, rst_n=0): state IDLE, dec_out=0, idx_out=0, busy=0, done=0, counters=0.
- States: IDLE, DIRECT, SCAN, PULSE. dec_out is never more than one-hot.
- en=0 from any state: next edge -> IDLE, dec_out=0, busy=0, done=0, counters cleared. An aborted PULSE gives no done.
- IDLE, en=1: mode 00 -> DIRECT; 01 -> SCAN; 10 with start=1 -> PULSE; 10 without start, or 11 -> stay IDLE, dec_out=0.
- DIRECT: every edge dec_out <= 1<<sel_in, idx_out <= sel_in. If mode leaves 00, go to IDLE with dec_out=0 on that edge.
- SCAN: entry edge sets dec_out=1, idx_out=0, step counter 0. Every SCAN_DIV cycles idx advances by 1 mod OUT_W.
  - On the step OUT_W-1 -> 0, done=1 for that cycle.
  - If mode leaves 01, go to IDLE with dec_out=0 on that edge.
- PULSE: start edge latches sel_in. dec_out=1<<latched index and busy=1 for exactly PULSE_LEN cycles.
  - Then one cycle with dec_out=0, busy=0, done=1, in IDLE.
  - start and mode changes are ignored while busy; only en=0 or reset aborts.
- OFF (11): outputs held at 0 and state IDLE.
- Pulse counter width is 8 bits; it counts PULSE_LEN-1 down to 0. Scan divider is 8 bits and counts up to SCAN_DIV-1, then wraps.

## Timing
- DIRECT latency: 1 cycle from sel_in to dec_out.
- SCAN: first line asserted 1 cycle after mode=01 is seen in IDLE. Each line is held SCAN_DIV cycles. Full period is OUT_W*SCAN_DIV cycles.
- PULSE: start at edge k -> dec_out/busy high on cycles k+1..k+PULSE_LEN; done high on cycle k+PULSE_LEN+1.
  - Earliest re-trigger: start sampled on the done cycle is accepted. Back-to-back pulses are separated by exactly one idle cycle.
- Simultaneous en=0 and start: en wins, and no pulse occurs.
- Reset asserted mid-operation clears outputs immediately, without waiting for a clock edge. After deassertion, the first edge behaves as from IDLE.

## Structure
- Shared package cap17_sel_pkg holds:
  - mode constants MODE_DIRECT/SCAN/PULSE/OFF;
  - state encoding constants ST_IDLE/DIRECT/SCAN/PULSE (2 bits);
  - the 8-bit counter width constant.
- Sub-module sel_onehot_dec is the combinational SEL_W -> OUT_W decoder with enable. It is instantiated once; its output feeds the dec_out register.
- The FSM, the scan divider and the pulse counter live in onehot_select_unit.

## Test plan
- Reset: hold rst_n=0 mid-PULSE -> dec_out=0, busy=0, done=0 immediately, with no clock edge required.
- DIRECT, SEL_W=3: sel_in=5, en=1 -> dec_out=8'b0010_0000, idx_out=5 one cycle later. Drop en -> dec_out=0 next cycle.
- SCAN, SEL_W=3, SCAN_DIV=2: dec_out walks 0x01,0x01,0x02,0x02,...,0x80,0x80,0x01. done=1 on the cycle 0x80 -> 0x01.
- PULSE, PULSE_LEN=4: start with sel_in=3 -> dec_out=0x08 and busy=1 for 4 cycles, then done=1 for 1 cycle. A second start during busy is ignored.
- Abort: en=0 on the 2nd PULSE cycle -> dec_out=0, busy=0 next cycle, and done never asserts.
- SEL_W=4 build: sel_in=15 in DIRECT -> dec_out=16'h8000. Check the one-hot invariant over random mode/start/en stimulus.
